output_word_collector: RTL and testbench
========================================

# output_word_collector

Registered collection stage downstream of the 5-bit-in / 10-bit-out combinational transform block. It accepts the transform's 10-bit result words over a valid/ready handshake and buffers them in a small FIFO for a downstream consumer. It also keeps a rotating XOR signature and a word count, so the result stream can be checked without inspecting every word.

## Interface
Parameters:
- DATA_W, default 10: word width; equals the transform block's output width.
- DEPTH, default 4: FIFO entries; must be a power of two and ≥ 2.
- CNT_W, default 16: width of the accepted-word counter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  in_data holds a word to accept.
- in_data  input  DATA_W  result word from the transform stage's output_data.
- in_ready  output  1  FIFO can accept a word.
- out_valid  output  1  out_data holds the oldest buffered word.
- out_data  output  DATA_W  head of FIFO; 0 when out_valid=0.
- out_ready  input  1  consumer takes the head word.
- level  output  $clog2(DEPTH)+1  number of buffered words, 0..DEPTH.
- sig  output  DATA_W  rotating XOR signature of accepted words.
- word_count  output  CNT_W  accepted words since reset or clear; saturating.
- drop  output  1  sticky: a word was offered while in_ready=0.
- clr  input  1  synchronous clear of sig, word_count and drop; FIFO contents are untouched.

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (level != DEPTH). It is combinational from registered state only, with no path from out_ready.
- out_valid = (level != 0). out_data = mem[rd_ptr] when valid, else 0.
- Occupancy states are implied by level:
  - EMPTY (0): only a push is possible.
  - PARTIAL: push and/or pop.
  - FULL (DEPTH): only a pop is possible.
- Level transitions:
  - push only: level+1.
  - pop only: level−1.
  - push and pop together: level unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- On each push:
  - sig ← rotl1(sig) ^ in_data, where rotl1 is a 1-bit left rotate over DATA_W bits.
  - word_count ← word_count+1, saturating at 2^CNT_W−1 (no wrap).
- in_valid=1 with in_ready=0: the word is discarded, drop ← 1, and nothing else changes.
- drop stays set until rst or clr.
- clr in the same cycle as a push: the result equals clear-then-push, i.e. sig = in_data and word_count = 1.
- clr in the same cycle as a drop event: drop ends at 1, because the new event wins.
- FIFO order is strict first-in first-out; no word is ever duplicated or reordered.

## Timing
- Reset values: level=0, out_valid=0, out_data=0, in_ready=1, sig=0, word_count=0, drop=0, both pointers 0.
- Reset takes effect immediately on assertion, independent of clk.
- rst asserted mid-stream empties the FIFO; buffered words are lost, with no partial output.
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 in the cycle after edge N, provided the FIFO was empty.
- Throughput: one push and one pop per cycle sustained at any level from 1 to DEPTH−1.
- At FULL, a same-cycle pop does not admit a push, because in_ready is already 0. in_ready rises the cycle after the pop.
- sig, word_count and drop update on the same edge as the triggering push, drop event or clr.

## Test plan
- Reset check: assert rst asynchronously mid-cycle → all outputs equal their reset values before the next edge; in_ready=1.
- Fill and overflow: push 0x101, 0x0F2, 0x3FF, 0x000 with out_ready=0 → level=4, in_ready=0. Then offer 0x055 → drop=1, level stays 4, word_count=4.
- Drain order: from the full state, out_ready=1 for 4 cycles → out_data reads 0x101, 0x0F2, 0x3FF, 0x000, then out_valid=0 and out_data=0. Pointers wrap correctly on a second fill.
- Signature: after clr, push 0x001 then 0x002 → sig=0x001 after the first push and 0x000 after the second. Then push 0x200 → sig=0x200.
- Simultaneous events:
  - push and pop together at level 2 → level stays 2 and order is preserved.
  - clr with push of 0x155 → sig=0x155, word_count=1, drop=0.
- Reset mid-operation: at level 3 with sig≠0, pulse rst → level=0, sig=0. The next pushed word 0x0AA is the first one out.

Source files
------------

// File: rtl/output_word_collector.sv
// Collection stage for the transform's result words: a small FIFO behind a
// valid/ready handshake, plus a rotating XOR signature, word count and drop flag.
module output_word_collector #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DATA_W-1:0]          sig,
    output logic [CNT_W-1:0]           word_count,
    output logic                       drop,
    input  logic                       clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;

    logic              push, pop, drop_evt;
    logic [DATA_W-1:0] sig_base;
    logic [CNT_W-1:0]  cnt_base;

    // Handshake flags depend on registered occupancy only, never on out_ready.
    assign in_ready   = (level_q != LVL_W'(DEPTH));
    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign sig        = sig_q;
    assign word_count = cnt_q;
    assign drop       = drop_q;

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign drop_evt = in_valid & ~in_ready;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Clear is applied first so a same-cycle push lands on a clean state.
        sig_base = clr ? '0 : sig_q;
        cnt_base = clr ? '0 : cnt_q;
        sig_d    = sig_base;
        cnt_d    = cnt_base;
        if (push) begin
            sig_d = {sig_base[DATA_W-2:0], sig_base[DATA_W-1]} ^ in_data;
            if (cnt_base != '1) cnt_d = cnt_base + CNT_W'(1);
        end
        drop_d = (clr ? 1'b0 : drop_q) | drop_evt;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their next values from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            sig_q    <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: storage is not reset; stale entries are unreachable because
    // out_data is forced to 0 whenever level is 0.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_output_word_collector.sv
// Self-checking bench for output_word_collector: directed vector table, corner
// sequences, then random traffic against a queue-based reference model.
module tb_output_word_collector;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, out_ready, clr;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, out_valid, drop;
    logic [DATA_W-1:0] out_data, sig;
    logic [2:0]        level;
    logic [CNT_W-1:0]  word_count;

    int n_total = 0;
    int n_pass  = 0;

    output_word_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .sig(sig), .word_count(word_count), .drop(drop),
        .clr(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              r;
        logic              c;
        logic [2:0]        lvl;
        logic              ir;
        logic [DATA_W-1:0] od;
        logic [DATA_W-1:0] sg;
        logic [CNT_W-1:0]  cnt;
        logic              dr;
    } vec_t;

    vec_t vecs[15];

    // Reference model state
    int unsigned m_q[$];
    int unsigned m_sig;
    int unsigned m_cnt;
    bit          m_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic c);
        in_valid = v; in_data = d; out_ready = r; clr = c;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic int unsigned rotl(input int unsigned s);
        return ((s * 2) % (1 << DATA_W)) + (s / (1 << (DATA_W - 1)));
    endfunction

    task automatic model_reset();
        m_q.delete(); m_sig = 0; m_cnt = 0; m_drop = 0;
    endtask

    // One clock of the reference model, using the pre-edge occupancy.
    task automatic model_step(input bit v, input int unsigned d, input bit r, input bit c);
        bit full, do_push, do_pop;
        full    = (m_q.size() == DEPTH);
        do_push = v && !full;
        do_pop  = r && (m_q.size() != 0);
        if (c) begin m_sig = 0; m_cnt = 0; m_drop = 0; end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            m_q.push_back(d);
            m_sig = rotl(m_sig) ^ d;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        if (v && full) m_drop = 1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " level"},     32'(level),      32'(m_q.size()));
        check({tag, " in_ready"},  32'(in_ready),   32'(m_q.size() != DEPTH));
        check({tag, " out_valid"}, 32'(out_valid),  32'(m_q.size() != 0));
        check({tag, " out_data"},  32'(out_data),   (m_q.size() != 0) ? m_q[0] : 0);
        check({tag, " sig"},       32'(sig),        m_sig);
        check({tag, " count"},     32'(word_count), m_cnt);
        check({tag, " drop"},      32'(drop),       32'(m_drop));
    endtask

    initial begin
        //             v  d       r  c   lvl ir  od      sg      cnt dr
        vecs[0]  = '{1, 10'h101, 0, 0, 1, 1, 10'h101, 10'h101, 1, 0};
        vecs[1]  = '{1, 10'h0F2, 0, 0, 2, 1, 10'h101, 10'h2F0, 2, 0};
        vecs[2]  = '{1, 10'h3FF, 0, 0, 3, 1, 10'h101, 10'h21E, 3, 0};
        vecs[3]  = '{1, 10'h000, 0, 0, 4, 0, 10'h101, 10'h03D, 4, 0};
        vecs[4]  = '{1, 10'h055, 0, 0, 4, 0, 10'h101, 10'h03D, 4, 1};
        vecs[5]  = '{0, 10'h000, 1, 0, 3, 1, 10'h0F2, 10'h03D, 4, 1};
        vecs[6]  = '{0, 10'h000, 1, 0, 2, 1, 10'h3FF, 10'h03D, 4, 1};
        vecs[7]  = '{0, 10'h000, 1, 0, 1, 1, 10'h000, 10'h03D, 4, 1};
        vecs[8]  = '{0, 10'h000, 1, 0, 0, 1, 10'h000, 10'h03D, 4, 1};
        vecs[9]  = '{0, 10'h000, 0, 1, 0, 1, 10'h000, 10'h000, 0, 0};
        vecs[10] = '{1, 10'h001, 0, 0, 1, 1, 10'h001, 10'h001, 1, 0};
        vecs[11] = '{1, 10'h002, 1, 0, 1, 1, 10'h002, 10'h000, 2, 0};
        vecs[12] = '{1, 10'h200, 1, 0, 1, 1, 10'h200, 10'h200, 3, 0};
        vecs[13] = '{1, 10'h155, 1, 1, 1, 1, 10'h155, 10'h155, 1, 0};
        vecs[14] = '{0, 10'h000, 1, 0, 0, 1, 10'h000, 10'h155, 1, 0};

        rst = 1'b1;
        drive(0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset level",    32'(level), 0);
        check("reset in_ready", 32'(in_ready), 1);
        check("reset out_data", 32'(out_data), 0);
        check("reset sig",      32'(sig), 0);

        // Directed table: fill, overflow, drain, signature, clr with push.
        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
            tick();
            check($sformatf("vec%0d level", i),     32'(level),      32'(vecs[i].lvl));
            check($sformatf("vec%0d in_ready", i),  32'(in_ready),   32'(vecs[i].ir));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid),  32'(vecs[i].lvl != 0));
            check($sformatf("vec%0d out_data", i),  32'(out_data),   32'(vecs[i].od));
            check($sformatf("vec%0d sig", i),       32'(sig),        32'(vecs[i].sg));
            check($sformatf("vec%0d count", i),     32'(word_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d drop", i),      32'(drop),       32'(vecs[i].dr));
        end

        // Push+pop at level 2 keeps level and order.
        drive(1, 10'h011, 0, 0); tick();
        drive(1, 10'h022, 0, 0); tick();
        drive(1, 10'h033, 1, 0); tick();
        check("pp level", 32'(level), 2);
        check("pp head",  32'(out_data), 32'h022);
        drive(0, '0, 1, 0); tick();
        check("pp next",  32'(out_data), 32'h033);
        drive(1, 10'h044, 0, 0); tick();
        drive(1, 10'h055, 0, 0); tick();
        drive(1, 10'h066, 0, 0); tick();
        check("full level", 32'(level), 4);

        // At FULL a same-cycle pop does not admit the offered word.
        drive(1, 10'h077, 1, 0); tick();
        check("full pop level", 32'(level), 3);
        check("full pop drop",  32'(drop), 1);
        check("full pop head",  32'(out_data), 32'h044);
        drive(1, 10'h088, 0, 0); tick();
        check("refill level", 32'(level), 4);

        // clr coincident with a drop event leaves drop set.
        drive(1, 10'h099, 0, 1); tick();
        check("clr+drop drop",  32'(drop), 1);
        check("clr+drop count", 32'(word_count), 0);
        check("clr+drop sig",   32'(sig), 0);
        check("clr+drop level", 32'(level), 4);

        // Asynchronous reset mid-cycle, checked before the next edge.
        drive(0, '0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("async level",     32'(level), 0);
        check("async out_valid", 32'(out_valid), 0);
        check("async out_data",  32'(out_data), 0);
        check("async in_ready",  32'(in_ready), 1);
        check("async drop",      32'(drop), 0);
        #1 rst = 1'b0;
        tick();

        // Reset mid-operation discards buffered words.
        drive(1, 10'h123, 0, 0); tick();
        drive(1, 10'h2BC, 0, 0); tick();
        drive(1, 10'h0F0, 0, 0); tick();
        check("midrst pre level", 32'(level), 3);
        check("midrst pre sig nz", 32'(sig != 0), 1);
        drive(0, '0, 0, 0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("midrst level", 32'(level), 0);
        check("midrst sig",   32'(sig), 0);
        @(posedge clk); #1;
        drive(1, 10'h0AA, 0, 0); tick();
        check("midrst first out", 32'(out_data), 32'h0AA);
        check("midrst level1",    32'(level), 1);

        // Random traffic against the reference model.
        drive(0, '0, 0, 0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        for (int n = 0; n < 3000; n++) begin
            logic v, r, c;
            logic [DATA_W-1:0] d;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 40) == 0);
            d = DATA_W'($urandom);
            drive(v, d, r, c);
            #1;
            check($sformatf("rnd%0d pre in_ready", n), 32'(in_ready), 32'(m_q.size() != DEPTH));
            model_step(v, d, r, c);
            @(posedge clk); #1;
            check_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
